// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IF/MEM single-port memory arbiter: FSM states, access
// size codes and the latched bus command payload.
package mem_port_arbiter_pkg;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned BE_W  = XLEN / 8;
   localparam int unsigned CNT_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DATA  = 2'd1,
      ST_INSTR = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef struct packed {
      logic            we;
      logic [XLEN-1:0] addr;
      logic [XLEN-1:0] wdata;
      logic [BE_W-1:0] be;
   } bus_cmd_t;

   // Mask of the right-justified bits that a given access size carries.
   function automatic logic [XLEN-1:0] size_mask(input logic [1:0] size);
      case (size)
         SZ_BYTE: size_mask = XLEN'(32'h0000_00FF);
         SZ_HALF: size_mask = XLEN'(32'h0000_FFFF);
         SZ_WORD: size_mask = XLEN'(32'hFFFF_FFFF);
         default: size_mask = XLEN'(32'hFFFF_FFFF);
      endcase
   endfunction

endpackage

// File: rtl/mem_port_arbiter_lane.sv
// Byte-lane steering: byte enables and store data shifted to the address offset,
// load data extracted back to the right-justified, zero-extended form.
module mem_lane_align
   import mem_port_arbiter_pkg::*;
(
   input  logic [1:0]      size_i,
   input  logic [1:0]      offset_i,
   input  logic [XLEN-1:0] wdata_i,
   input  logic [XLEN-1:0] rdata_i,
   output logic [BE_W-1:0] be_o,
   output logic [XLEN-1:0] wdata_o,
   output logic [XLEN-1:0] rdata_o,
   output logic            misaligned_o
);

   logic [4:0] shamt;

   assign shamt = {offset_i, 3'b000};

   always_comb begin
      be_o         = 4'b1111;
      misaligned_o = 1'b0;
      case (size_i)
         SZ_BYTE: be_o = 4'b0001 << offset_i;
         SZ_HALF: begin
            be_o         = 4'b0011 << offset_i;
            misaligned_o = offset_i[0];
         end
         default: misaligned_o = |offset_i;
      endcase
      wdata_o = (wdata_i & size_mask(size_i)) << shamt;
      rdata_o = (rdata_i >> shamt) & size_mask(size_i);
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory bus between instruction fetch and the MEM
// stage; MEM has priority, each access is a req/ack handshake with a timeout.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_ready,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [1:0]  mem_size,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   output logic [31:0] mem_rdata,
   output logic        mem_done,
   output logic        misalign_exc,
   output logic        bus_err,
   output logic        stall,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_be,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata
);

   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [XLEN-1:0]  WORD_MSK = ~XLEN'(3);

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   bus_cmd_t         cmd_q;
   logic             bus_req_q;
   logic [1:0]       size_q;
   logic [1:0]       off_q;
   logic [XLEN-1:0]  mem_rdata_q;
   logic [XLEN-1:0]  if_rdata_q;
   logic             mem_done_q;
   logic             if_ready_q;
   logic             misalign_q;
   logic             bus_err_q;

   logic             mem_rw;
   logic [1:0]       al_size;
   logic [1:0]       al_off;
   logic [BE_W-1:0]  al_be;
   logic [XLEN-1:0]  al_wdata;
   logic [XLEN-1:0]  al_rdata;
   logic             al_misaligned;

   assign mem_rw = mem_read | mem_write;

   // Live request fields while deciding in IDLE, latched ones while the access runs.
   assign al_size = (state_q == ST_IDLE) ? mem_size      : size_q;
   assign al_off  = (state_q == ST_IDLE) ? mem_addr[1:0] : off_q;

   mem_lane_align u_lane (
      .size_i       (al_size),
      .offset_i     (al_off),
      .wdata_i      (mem_wdata),
      .rdata_i      (bus_rdata),
      .be_o         (al_be),
      .wdata_o      (al_wdata),
      .rdata_o      (al_rdata),
      .misaligned_o (al_misaligned)
   );

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         cmd_q       <= '0;
         bus_req_q   <= 1'b0;
         size_q      <= SZ_BYTE;
         off_q       <= 2'b00;
         mem_rdata_q <= '0;
         if_rdata_q  <= '0;
         mem_done_q  <= 1'b0;
         if_ready_q  <= 1'b0;
         misalign_q  <= 1'b0;
         bus_err_q   <= 1'b0;
      end else begin
         mem_done_q <= 1'b0;
         if_ready_q <= 1'b0;
         misalign_q <= 1'b0;
         bus_err_q  <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (mem_rw) begin
                  if (al_misaligned) begin
                     misalign_q <= 1'b1;
                     mem_done_q <= 1'b1;
                     state_q    <= ST_DONE;
                  end else begin
                     bus_req_q   <= 1'b1;
                     cmd_q.we    <= mem_write;
                     cmd_q.addr  <= mem_addr & WORD_MSK;
                     cmd_q.wdata <= al_wdata;
                     cmd_q.be    <= al_be;
                     size_q      <= mem_size;
                     off_q       <= mem_addr[1:0];
                     cnt_q       <= '0;
                     state_q     <= ST_DATA;
                  end
               end else if (if_req) begin
                  bus_req_q   <= 1'b1;
                  cmd_q.we    <= 1'b0;
                  cmd_q.addr  <= if_addr & WORD_MSK;
                  cmd_q.wdata <= '0;
                  cmd_q.be    <= 4'b1111;
                  cnt_q       <= '0;
                  state_q     <= ST_INSTR;
               end
            end
            ST_DATA, ST_INSTR: begin
               // Ack wins over a timeout that expires in the same cycle.
               if (bus_ack || (cnt_q == TMO_LAST)) begin
                  bus_req_q <= 1'b0;
                  cmd_q     <= '0;
                  cnt_q     <= '0;
                  bus_err_q <= ~bus_ack;
                  state_q   <= ST_DONE;
                  if (state_q == ST_DATA) begin
                     mem_done_q  <= 1'b1;
                     mem_rdata_q <= bus_ack ? al_rdata : '0;
                  end else begin
                     if_ready_q <= 1'b1;
                     if_rdata_q <= bus_ack ? bus_rdata : '0;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            ST_DONE: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus_req      = bus_req_q;
   assign bus_we       = cmd_q.we;
   assign bus_addr     = cmd_q.addr;
   assign bus_wdata    = cmd_q.wdata;
   assign bus_be       = cmd_q.be;
   assign mem_rdata    = mem_rdata_q;
   assign if_rdata     = if_rdata_q;
   assign mem_done     = mem_done_q;
   assign if_ready     = if_ready_q;
   assign misalign_exc = misalign_q;
   assign bus_err      = bus_err_q;

   // Stall is a function of the live pipeline requests; forced low during reset.
   assign stall = RESET & ((mem_rw & ~mem_done_q) | (if_req & ~if_ready_q & ~mem_rw));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: random IF/MEM traffic against a
// behavioural model, with a bus responder that also acts as the output monitor.
module tb_mem_port_arbiter;

   localparam int unsigned TIMEOUT = 15;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_ready;
   logic        mem_read;
   logic        mem_write;
   logic [1:0]  mem_size;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_done;
   logic        misalign_exc;
   logic        bus_err;
   logic        stall;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_be;
   logic        bus_ack = 1'b0;
   logic [31:0] bus_rdata = 32'h0;

   always #5 CLK = ~CLK;

   mem_port_arbiter #(.TIMEOUT(TIMEOUT)) dut (
      .CLK(CLK), .RESET(RESET),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
      .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_done(mem_done), .misalign_exc(misalign_exc), .bus_err(bus_err),
      .stall(stall), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
   );

   typedef struct {
      bit          is_mem;
      bit          misalign;
      bit          timeout;
      bit          we;
      bit          chk_rdata;
      int          req_cycles;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic [3:0]  be;
   } exp_t;

   typedef struct {
      int          ack_at;
      logic [31:0] rdata;
   } plan_t;

   exp_t  exp_q[$];
   plan_t plan_q[$];
   int    n_chk  = 0;
   int    n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
      end
   endtask

   task automatic finish_tb();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   endtask

   // Reference model of a MEM access: plain arithmetic on sizes and offsets.
   function automatic exp_t model_mem(input bit wr, input logic [1:0] sz, input logic [31:0] addr,
                                      input logic [31:0] wdata, input int ack_at,
                                      input logic [31:0] brdata);
      exp_t            e;
      int              n;
      int              off;
      longint unsigned lanes;
      n            = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      off          = int'(addr % 4);
      e.is_mem     = 1'b1;
      e.misalign   = (int'(addr % 32'(n)) != 0);
      e.we         = wr;
      e.chk_rdata  = !wr && !e.misalign;
      e.timeout    = !e.misalign && (ack_at == 0);
      e.req_cycles = e.misalign ? 0 : ((ack_at == 0) ? int'(TIMEOUT) : ack_at);
      e.addr       = addr - 32'(off);
      e.be         = 4'(((1 << n) - 1) << off);
      lanes        = 64'(wdata) % (64'd1 << (8 * n));
      e.wdata      = 32'(lanes << (8 * off));
      e.rdata      = e.timeout ? 32'h0 : 32'((64'(brdata) >> (8 * off)) % (64'd1 << (8 * n)));
      return e;
   endfunction

   function automatic exp_t model_if(input logic [31:0] addr, input int ack_at,
                                     input logic [31:0] brdata);
      exp_t e;
      e.is_mem     = 1'b0;
      e.misalign   = 1'b0;
      e.we         = 1'b0;
      e.chk_rdata  = 1'b1;
      e.timeout    = (ack_at == 0);
      e.req_cycles = e.timeout ? int'(TIMEOUT) : ack_at;
      e.addr       = addr - (addr % 4);
      e.be         = 4'hF;
      e.wdata      = 32'h0;
      e.rdata      = e.timeout ? 32'h0 : brdata;
      return e;
   endfunction

   // Bus responder and scoreboard monitor.
   int          cyc = 0;
   int          cur_ack = 0;
   logic [31:0] cur_rdata = 32'h0;
   bit          acked_last = 1'b0;
   logic [31:0] seen_addr, seen_wdata;
   logic [3:0]  seen_be;
   logic        seen_we;

   always @(negedge CLK) begin
      exp_t  e;
      plan_t p;
      if (!RESET) begin
         cyc        = 0;
         cur_ack    = 0;
         acked_last = 1'b0;
         bus_ack    = 1'b0;
      end else begin
         check("stall", 32'(stall),
               32'(((mem_read | mem_write) & ~mem_done) | (if_req & ~if_ready & ~(mem_read | mem_write))));
         if (mem_done || if_ready) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_done: mem_done=%0b if_ready=%0b with empty scoreboard",
                        mem_done, if_ready);
            end else begin
               e = exp_q.pop_front();
               check("done_kind", {30'd0, mem_done, if_ready}, e.is_mem ? 32'd2 : 32'd1);
               check("misalign_exc", 32'(misalign_exc), 32'(e.misalign));
               check("bus_err", 32'(bus_err), 32'(e.timeout));
               check("req_cycles", 32'(cyc), 32'(e.req_cycles));
               if (e.req_cycles > 0 && cyc > 0) begin
                  check("bus_addr", seen_addr, e.addr);
                  check("bus_be", 32'(seen_be), 32'(e.be));
                  check("bus_we", 32'(seen_we), 32'(e.we));
                  if (e.we) check("bus_wdata", seen_wdata, e.wdata);
               end
               if (e.chk_rdata) check("rdata", e.is_mem ? mem_rdata : if_rdata, e.rdata);
               if (!e.timeout && !e.misalign) check("done_latency", 32'(acked_last), 32'd1);
            end
            cyc = 0;
         end else begin
            check("idle_pulses", {30'd0, misalign_exc, bus_err}, 32'd0);
         end
         acked_last = 1'b0;
         bus_ack    = 1'b0;
         bus_rdata  = $urandom;
         if (bus_req) begin
            cyc++;
            check("bus_addr_align", 32'(bus_addr[1:0]), 32'd0);
            if (cyc == 1) begin
               seen_addr  = bus_addr;
               seen_wdata = bus_wdata;
               seen_be    = bus_be;
               seen_we    = bus_we;
               cur_ack    = 0;
               if (plan_q.size() > 0) begin
                  p         = plan_q.pop_front();
                  cur_ack   = p.ack_at;
                  cur_rdata = p.rdata;
               end
            end else begin
               check("bus_stable", {bus_addr[31:4], bus_be},
                     {seen_addr[31:4], seen_be});
            end
            if (cur_ack == cyc) begin
               bus_ack    = 1'b1;
               bus_rdata  = cur_rdata;
               acked_last = 1'b1;
            end
         end else if ($urandom_range(0, 3) == 0) begin
            bus_ack = 1'b1;
         end
      end
   end

   task automatic wait_pulse(input bit want_mem, input bit scramble);
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 60 && !seen; k++) begin
         @(negedge CLK);
         seen = want_mem ? mem_done : if_ready;
         if (!seen && k == 0 && scramble) begin
            #1;
            mem_addr  = $urandom;
            mem_wdata = $urandom;
            mem_size  = 2'($urandom_range(0, 3));
         end
      end
      if (!seen) begin
         n_chk++;
         n_fail++;
         $display("FAIL wait_%s: no completion pulse within 60 cycles", want_mem ? "mem" : "if");
         finish_tb();
      end
   endtask

   task automatic run_txn(input bit do_mem, input bit do_if, input bit rd, input bit wr,
                          input logic [1:0] sz, input logic [31:0] maddr, input logic [31:0] mwdata,
                          input int m_ack, input logic [31:0] m_rdata,
                          input logic [31:0] iaddr, input int i_ack, input logic [31:0] i_rdata);
      exp_t  e;
      plan_t p;
      bit    has_mem;
      has_mem = do_mem && (rd || wr);
      if (has_mem) begin
         e = model_mem(wr, sz, maddr, mwdata, m_ack, m_rdata);
         exp_q.push_back(e);
         if (!e.misalign) begin
            p.ack_at = m_ack;
            p.rdata  = m_rdata;
            plan_q.push_back(p);
         end
      end
      if (do_if) begin
         exp_q.push_back(model_if(iaddr, i_ack, i_rdata));
         p.ack_at = i_ack;
         p.rdata  = i_rdata;
         plan_q.push_back(p);
      end
      @(negedge CLK);
      #1;
      mem_read  = has_mem && rd;
      mem_write = has_mem && wr;
      mem_size  = sz;
      mem_addr  = maddr;
      mem_wdata = mwdata;
      if_req    = do_if;
      if_addr   = iaddr;
      if (has_mem) begin
         wait_pulse(1'b1, 1'b1);
         #1;
         mem_read  = 1'b0;
         mem_write = 1'b0;
      end
      if (do_if) begin
         wait_pulse(1'b0, 1'b0);
         #1;
         if_req  = 1'b0;
         if_addr = $urandom;
      end
      repeat ($urandom_range(0, 2)) @(negedge CLK);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_bus_req"}, 32'(bus_req), 32'd0);
      check({tag, "_bus_we"}, 32'(bus_we), 32'd0);
      check({tag, "_bus_addr"}, bus_addr, 32'd0);
      check({tag, "_bus_be"}, 32'(bus_be), 32'd0);
      check({tag, "_bus_wdata"}, bus_wdata, 32'd0);
      check({tag, "_pulses"}, {28'd0, mem_done, if_ready, misalign_exc, bus_err}, 32'd0);
      check({tag, "_stall"}, 32'(stall), 32'd0);
      check({tag, "_mem_rdata"}, mem_rdata, 32'd0);
      check({tag, "_if_rdata"}, if_rdata, 32'd0);
   endtask

   function automatic int rand_ack();
      int r;
      r = int'($urandom_range(0, 9));
      if (r == 0) return 0;
      if (r == 1) return int'(TIMEOUT);
      return int'($urandom_range(1, 4));
   endfunction

   initial begin
      RESET     = 1'b0;
      if_req    = 1'b0;
      if_addr   = 32'h0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem_size  = 2'b00;
      mem_addr  = 32'h0;
      mem_wdata = 32'h0;
      repeat (2) @(negedge CLK);
      check_all_zero("reset");
      #1;
      RESET = 1'b1;

      // Directed: word load, byte store, misaligned half, contention, timeouts.
      run_txn(1, 0, 1, 0, 2'b10, 32'h100, 32'h0, 3, 32'hDEADBEEF, 32'h0, 0, 32'h0);
      run_txn(1, 0, 0, 1, 2'b00, 32'h103, 32'hAB, 2, 32'h0, 32'h0, 0, 32'h0);
      run_txn(1, 0, 1, 0, 2'b01, 32'h201, 32'h0, 1, 32'h0, 32'h0, 0, 32'h0);
      run_txn(1, 1, 1, 0, 2'b10, 32'h300, 32'h0, 2, 32'h11223344, 32'h406, 1, 32'hCAFEF00D);
      run_txn(1, 0, 1, 0, 2'b10, 32'h500, 32'h0, 0, 32'h0, 32'h0, 0, 32'h0);
      run_txn(0, 1, 0, 0, 2'b00, 32'h0, 32'h0, 0, 32'h0, 32'h800, 0, 32'h12345678);
      run_txn(1, 0, 1, 1, 2'b01, 32'h002, 32'h9876ABCD, 15, 32'h0, 32'h0, 0, 32'h0);
      run_txn(1, 0, 1, 0, 2'b00, 32'h0FE, 32'h0, 1, 32'hA1B2C3D4, 32'h0, 0, 32'h0);

      for (int t = 0; t < 150; t++) begin
         int         kind;
         int         rw;
         bit         rd;
         bit         wr;
         kind = int'($urandom_range(0, 3));
         rw   = int'($urandom_range(0, 4));
         rd   = (rw <= 1) || (rw == 4);
         wr   = (rw >= 2);
         run_txn(kind != 2, kind >= 2, rd, wr, 2'($urandom_range(0, 3)), $urandom, $urandom,
                 rand_ack(), $urandom, $urandom, rand_ack(), $urandom);
      end

      // Reset in the middle of a pending data access.
      @(negedge CLK);
      #1;
      mem_read = 1'b1;
      mem_size = 2'b10;
      mem_addr = 32'h600;
      repeat (4) @(negedge CLK);
      check("rst_pre_bus_req", 32'(bus_req), 32'd1);
      #2;
      RESET = 1'b0;
      #1;
      check_all_zero("midreset");
      mem_read = 1'b0;
      exp_q.delete();
      plan_q.delete();
      repeat (2) @(negedge CLK);
      #1;
      RESET = 1'b1;
      run_txn(1, 0, 1, 0, 2'b01, 32'h702, 32'h0, 1, 32'h5566_7788, 32'h0, 0, 32'h0);
      run_txn(0, 1, 0, 0, 2'b00, 32'h0, 32'h0, 0, 32'h0, 32'h904, 2, 32'h0BAD_CAFE);

      repeat (3) @(negedge CLK);
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      finish_tb();
   end

endmodule
